fetch_unit: RTL and testbench

Instruction-fetch stage: owns the program counter, issues one outstanding read on the instruction bus, and produces the `if_id` pipeline register consumed by the decode stage. It sits between the instruction memory port and the decoder, applies downstream back-pressure, and discards wrong-path instructions when execute redirects the PC.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding bus request FSM, if_id register
//
// Ports:
//   clk, reset          core clock; synchronous active-high reset
//   ireq_valid/addr     fetch request to the instruction bus (one outstanding max)
//   iresp_addr_ok       bus accepted the request this cycle
//   iresp_data_ok/data  instruction word returned for the accepted request
//   if_id_state         registered {inst, inst_pc, valid} to decode
//   out_ready           decode consumes if_id_state this cycle when valid
//   redirect/_pc        single-cycle flush and refetch from redirect_pc

package fetch_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        valid;
  } if_id_t;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output if_id_t      if_id_state,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state;
  logic [63:0] pc;
  logic        kill;         // data of the in-flight request belongs to a flushed path
  logic        req_pending;  // request raised but not yet accepted: must be held
  logic [63:0] req_addr;     // address of the held request (pc may have moved on)
  if_id_t      out_q;

  logic accepted;
  logic stalled;
  logic data_in;

  // A new request is only started when the output slot is free or being
  // drained this cycle; once started it stays up until the bus takes it.
  always_comb begin
    ireq_valid = !reset && (state == S_REQ) &&
                 (req_pending || !out_q.valid || out_ready);
    ireq_addr  = req_pending ? req_addr : pc;
  end

  assign accepted    = ireq_valid && iresp_addr_ok;
  assign stalled     = ireq_valid && !iresp_addr_ok;
  assign data_in     = (state == S_WAIT) && iresp_data_ok;
  assign if_id_state = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      req_pending <= 1'b0;
      req_addr    <= '0;
      out_q       <= '0;
    end else begin
      // Request handshake bookkeeping is the same with or without redirect:
      // a committed request cannot be withdrawn.
      if (accepted) begin
        req_pending <= 1'b0;
        state       <= S_WAIT;
      end else if (stalled && !req_pending) begin
        req_pending <= 1'b1;
        req_addr    <= pc;
      end

      if (data_in) begin
        state <= S_REQ;
      end

      if (redirect) begin
        pc          <= redirect_pc;
        out_q.valid <= 1'b0;
        // Returning data this cycle is simply dropped; anything still on the
        // bus (held request or awaited data) must be discarded later.
        if (data_in) begin
          kill <= 1'b0;
        end else if (ireq_valid || state == S_WAIT) begin
          kill <= 1'b1;
        end
      end else begin
        if (out_q.valid && out_ready) begin
          out_q.valid <= 1'b0;
        end
        // A load in the same cycle as consumption overrides the clear above.
        if (data_in) begin
          if (kill) begin
            kill <= 1'b0;
          end else begin
            out_q.inst    <= iresp_data;
            out_q.inst_pc <= pc;
            out_q.valid   <= 1'b1;
            pc            <= pc + 64'd4;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with bus model and stream reference model

module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  if_id_t      if_id_state;
  logic        out_ready;
  logic        redirect;
  logic [63:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .if_id_state  (if_id_state),
    .out_ready    (out_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // bus model
  logic        busy = 1'b0;
  logic [63:0] baddr = '0;
  int          acnt = 0, dcnt = 0;
  int          a_lo = 0, a_hi = 0, d_lo = 0, d_hi = 0;

  // per-cycle samples and previous-cycle copies
  logic        s_req, s_aok, s_dok;
  logic [63:0] s_addr;
  if_id_t      s_out;
  logic        p_have = 1'b0;
  logic        p_req, p_aok, p_rst, p_rd, p_rdy;
  logic [63:0] p_addr;
  if_id_t      p_out;

  // reference: the address the next delivered instruction must come from
  logic [63:0] exp_pc = RST_PC;
  int          n_deliv = 0;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_bus(input int al, input int ah, input int dl, input int dh);
    a_lo = al; a_hi = ah; d_lo = dl; d_hi = dh;
  endtask

  task automatic cycle(input logic rst, input logic rdy, input logic rd, input logic [63:0] rpc);
    @(negedge clk);
    reset         = rst;
    out_ready     = rdy;
    redirect      = rd;
    redirect_pc   = rpc;
    iresp_data_ok = busy && (dcnt == 0);
    iresp_data    = iresp_data_ok ? mem(baddr) : 32'h0;
    #1;
    iresp_addr_ok = ireq_valid && (acnt == 0);
    #1;
    s_req  = ireq_valid;
    s_addr = ireq_addr;
    s_aok  = iresp_addr_ok;
    s_dok  = iresp_data_ok;
    s_out  = if_id_state;

    if (p_have && p_req && !p_aok && !p_rst && !rst) begin
      check("req_held_valid", s_req, 1);
      check("req_held_addr", s_addr, p_addr);
    end
    if (busy && !rst) check("one_outstanding", s_req, 0);
    if (p_have && p_out.valid && !p_rdy && !p_rd && !p_rst)
      check("out_hold", {31'd0, s_out}, {31'd0, p_out});

    if (rst) begin
      exp_pc = RST_PC;
    end else if (rd) begin
      exp_pc = rpc;
    end else if (s_out.valid && rdy) begin
      check("deliv_pc", s_out.inst_pc, exp_pc);
      check("deliv_inst", s_out.inst, mem(exp_pc));
      exp_pc = exp_pc + 64'd4;
      n_deliv++;
    end

    p_have = 1'b1; p_req = s_req; p_aok = s_aok; p_rst = rst;
    p_rd = rd; p_rdy = rdy; p_addr = s_addr; p_out = s_out;

    @(posedge clk);
    if (rst) begin
      busy = 1'b0;
      acnt = $urandom_range(a_hi, a_lo);
    end else begin
      if (s_dok) busy = 1'b0;
      else if (busy && dcnt > 0) dcnt--;
      if (s_req && s_aok) begin
        busy  = 1'b1;
        baddr = s_addr;
        dcnt  = $urandom_range(d_hi, d_lo);
        acnt  = $urandom_range(a_hi, a_lo);
      end else if (s_req && acnt > 0) begin
        acnt--;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [63:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic e_req,
                              input logic [63:0] e_addr, input logic e_ov, input logic [63:0] e_pc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    int base;
    logic [63:0] rpc;

    reset = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;

    // zero-wait bus: streaming, back-pressure hold, reset with a held output
    tbl[0]  = mk(1, 1, 0, 0,              0, 0);
    tbl[1]  = mk(0, 1, 1, RST_PC,         0, 0);
    tbl[2]  = mk(0, 1, 0, 0,              0, 0);
    tbl[3]  = mk(0, 1, 1, RST_PC + 64'd4, 1, RST_PC);
    tbl[4]  = mk(0, 1, 0, 0,              0, 0);
    tbl[5]  = mk(0, 1, 1, RST_PC + 64'd8, 1, RST_PC + 64'd4);
    tbl[6]  = mk(0, 1, 0, 0,              0, 0);
    tbl[7]  = mk(0, 0, 0, 0,              1, RST_PC + 64'd8);
    tbl[8]  = mk(1, 0, 0, 0,              1, RST_PC + 64'd8);
    tbl[9]  = mk(0, 0, 1, RST_PC,         0, 0);
    tbl[10] = mk(0, 0, 0, 0,              0, 0);
    for (int i = 11; i <= 15; i++) tbl[i] = mk(0, 0, 0, 0, 1, RST_PC);
    tbl[16] = mk(0, 1, 1, RST_PC + 64'd4, 1, RST_PC);
    tbl[17] = mk(0, 1, 0, 0,              0, 0);
    tbl[18] = mk(0, 1, 1, RST_PC + 64'd8, 1, RST_PC + 64'd4);

    set_bus(0, 0, 0, 0);
    cycle(1, 1, 0, '0);
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].rst, tbl[i].rdy, 1'b0, '0);
      check($sformatf("vec%0d_req", i), s_req, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("vec%0d_addr", i), s_addr, tbl[i].e_addr);
      check($sformatf("vec%0d_ov", i), s_out.valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d_pc", i), s_out.inst_pc, tbl[i].e_pc);
        check($sformatf("vec%0d_inst", i), s_out.inst, mem(tbl[i].e_pc));
      end
    end

    // addr_ok stalled 3 cycles, then redirect while waiting for data
    set_bus(3, 3, 0, 0);
    cycle(1, 1, 0, '0);
    set_bus(0, 0, 2, 2);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, '0);
      check($sformatf("stall%0d_req", k), s_req, 1);
      check($sformatf("stall%0d_addr", k), s_addr, RST_PC);
    end
    cycle(0, 1, 1, 64'h8000_0100);
    check("wait_redir_req", s_req, 0);
    set_bus(0, 0, 0, 0);
    cycle(0, 1, 0, '0);
    check("wait_redir_ov_a", s_out.valid, 0);
    cycle(0, 1, 0, '0);
    check("wait_redir_ov_b", s_out.valid, 0);
    cycle(0, 1, 0, '0);
    check("wait_redir_ov_c", s_out.valid, 0);
    check("wait_redir_newreq", s_req, 1);
    check("wait_redir_newaddr", s_addr, 64'h8000_0100);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    check("wait_redir_deliv_ov", s_out.valid, 1);
    check("wait_redir_deliv_pc", s_out.inst_pc, 64'h8000_0100);

    // redirect while output held, then redirect on the data_ok cycle
    set_bus(0, 0, 0, 0);
    cycle(1, 1, 0, '0);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);
    check("held_ov", s_out.valid, 1);
    check("held_noreq", s_req, 0);
    cycle(0, 0, 1, 64'h8000_0200);
    check("held_redir_noreq", s_req, 0);
    cycle(0, 0, 0, '0);
    check("held_redir_ov", s_out.valid, 0);
    check("held_redir_addr", s_addr, 64'h8000_0200);
    cycle(0, 0, 1, 64'h8000_0300);
    check("dok_redir_dok", s_dok, 1);
    cycle(0, 0, 0, '0);
    check("dok_redir_ov", s_out.valid, 0);
    check("dok_redir_req", s_req, 1);
    check("dok_redir_addr", s_addr, 64'h8000_0300);
    cycle(0, 0, 0, '0);
    cycle(0, 1, 0, '0);
    check("dok_redir_deliv_pc", s_out.inst_pc, 64'h8000_0300);
    check("dok_redir_deliv_ov", s_out.valid, 1);

    // reset while waiting for data, then PC wrap through 2^64
    set_bus(0, 0, 3, 3);
    cycle(1, 1, 0, '0);
    cycle(0, 1, 0, '0);
    set_bus(0, 0, 0, 0);
    cycle(1, 1, 0, '0);
    check("midrst_req", s_req, 0);
    cycle(0, 1, 0, '0);
    check("midrst_out", {31'd0, s_out}, 128'd0);
    check("midrst_addr", s_addr, RST_PC);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_first_pc", s_out.inst_pc, RST_PC);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    check("wrap_req_addr", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    check("wrap_deliv_pc", s_out.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next_addr", s_addr, 64'h0);

    // random traffic against the stream model
    set_bus(0, 3, 0, 3);
    cycle(1, 1, 0, '0);
    base = n_deliv;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(3, 0) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      else rpc = {$urandom, $urandom};
      cycle($urandom_range(299, 0) == 0, $urandom_range(3, 0) != 0,
            $urandom_range(15, 0) == 0, rpc);
    end
    check("random_progress", (n_deliv - base) > 200, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
